// File: rtl/axi_read_arbiter_if.sv
// Bundles every bus-level signal of the IFU/LSU read arbiter: the two
// upstream read masters, the LSU write-busy flag, the shared downstream
// AXI4-Lite read port and the grant counters.
// Modport "master" is the arbiter's view (it masters the shared port);
// modport "slave" is the surrounding system's view.
interface axi_read_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 32
);
    // IFU read channel
    logic [AW-1:0] ifu_araddr;
    logic          ifu_arvalid;
    logic          ifu_arready;
    logic [DW-1:0] ifu_rdata;
    logic [1:0]    ifu_rresp;
    logic          ifu_rvalid;
    logic          ifu_rready;

    // LSU read channel
    logic [AW-1:0] lsu_araddr;
    logic          lsu_arvalid;
    logic          lsu_arready;
    logic [DW-1:0] lsu_rdata;
    logic [1:0]    lsu_rresp;
    logic          lsu_rvalid;
    logic          lsu_rready;

    // LSU write path outstanding
    logic          wr_busy;

    // Shared downstream read port
    logic [AW-1:0] s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;

    // Completed-read counters
    logic [CW-1:0] ifu_grants;
    logic [CW-1:0] lsu_grants;

    modport master (
        input  ifu_araddr, ifu_arvalid, ifu_rready,
        output ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
        input  lsu_araddr, lsu_arvalid, lsu_rready,
        output lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
        input  wr_busy,
        output s_araddr, s_arvalid, s_rready,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        output ifu_grants, lsu_grants
    );

    modport slave (
        output ifu_araddr, ifu_arvalid, ifu_rready,
        input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
        output lsu_araddr, lsu_arvalid, lsu_rready,
        input  lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
        output wr_busy,
        input  s_araddr, s_arvalid, s_rready,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        input  ifu_grants, lsu_grants
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Transaction-level round-robin arbiter sharing one AXI4-Lite read port
// between the IFU and the LSU. One read outstanding at a time; no new grant
// is issued while the LSU write path is busy so loads never pass a store.
// Counts completed reads per master (wrapping counters).
module axi_read_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 32
) (
    input logic               clock,
    input logic               reset,   // asynchronous, active-low
    axi_read_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // grant/last encoding: 0 = IFU, 1 = LSU
    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q,  last_d;
    logic [CW-1:0] ifu_cnt_q, ifu_cnt_d;
    logic [CW-1:0] lsu_cnt_q, lsu_cnt_d;

    // Signals of whichever master currently holds the grant
    logic          sel_arvalid;
    logic [AW-1:0] sel_araddr;
    logic          sel_rready;

    // Mux the granted master's request-side signals
    always_comb begin
        sel_arvalid = bus.ifu_arvalid;
        sel_araddr  = bus.ifu_araddr;
        sel_rready  = bus.ifu_rready;
        if (grant_q) begin
            sel_arvalid = bus.lsu_arvalid;
            sel_araddr  = bus.lsu_araddr;
            sel_rready  = bus.lsu_rready;
        end
    end

    // State, grant and counter registers; reset abandons any transaction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;   // IFU wins the first tie
            ifu_cnt_q <= '0;
            lsu_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            ifu_cnt_q <= ifu_cnt_d;
            lsu_cnt_q <= lsu_cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, advance on AR and R handshakes
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        ifu_cnt_d = ifu_cnt_q;
        lsu_cnt_d = lsu_cnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.wr_busy && (bus.ifu_arvalid || bus.lsu_arvalid)) begin
                    state_d = ADDR;
                    if (bus.ifu_arvalid && bus.lsu_arvalid) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = bus.lsu_arvalid;
                    end
                end
            end
            ADDR: begin
                // A master dropping arvalid here just stalls; no re-arbitration
                if (sel_arvalid && bus.s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.s_rvalid && sel_rready) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    if (grant_q) begin
                        lsu_cnt_d = lsu_cnt_q + CW'(1);
                    end else begin
                        ifu_cnt_d = ifu_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: steer the shared port to/from the granted master only
    always_comb begin
        bus.s_arvalid   = 1'b0;
        bus.s_araddr    = '0;
        bus.s_rready    = 1'b0;
        bus.ifu_arready = 1'b0;
        bus.lsu_arready = 1'b0;
        bus.ifu_rvalid  = 1'b0;
        bus.ifu_rdata   = '0;
        bus.ifu_rresp   = '0;
        bus.lsu_rvalid  = 1'b0;
        bus.lsu_rdata   = '0;
        bus.lsu_rresp   = '0;
        case (state_q)
            ADDR: begin
                bus.s_arvalid = sel_arvalid;
                bus.s_araddr  = sel_araddr;
                if (grant_q) begin
                    bus.lsu_arready = bus.s_arready;
                end else begin
                    bus.ifu_arready = bus.s_arready;
                end
            end
            DATA: begin
                bus.s_rready = sel_rready;
                if (grant_q) begin
                    bus.lsu_rvalid = bus.s_rvalid;
                    bus.lsu_rdata  = bus.s_rdata;
                    bus.lsu_rresp  = bus.s_rresp;
                end else begin
                    bus.ifu_rvalid = bus.s_rvalid;
                    bus.ifu_rdata  = bus.s_rdata;
                    bus.ifu_rresp  = bus.s_rresp;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.ifu_grants = ifu_cnt_q;
    assign bus.lsu_grants = lsu_cnt_q;

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI4-Lite read port (AR/R channels) to memory between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Transaction-level, round-robin arbitration with one outstanding read at a time.
- Holds off new grants while the LSU write path is busy, so reads never pass an in-flight store.
- Keeps per-master grant counters for performance reporting.

Parameters:
AW, 32, address width
DW, 32, data width
CW, 32, grant counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
ifu_araddr  in  AW  IFU read address
ifu_arvalid  in  1  IFU address valid
ifu_arready  out  1  IFU address accepted
ifu_rdata  out  DW  IFU read data
ifu_rresp  out  2  IFU read response
ifu_rvalid  out  1  IFU data valid
ifu_rready  in  1  IFU data ready
lsu_araddr  in  AW  LSU read address
lsu_arvalid  in  1  LSU address valid
lsu_arready  out  1  LSU address accepted
lsu_rdata  out  DW  LSU read data
lsu_rresp  out  2  LSU read response
lsu_rvalid  out  1  LSU data valid
lsu_rready  in  1  LSU data ready
wr_busy  in  1  LSU write transaction outstanding (AW issued, B not yet received)
s_araddr  out  AW  slave read address
s_arvalid  out  1  slave address valid
s_arready  in  1  slave address ready
s_rdata  in  DW  slave read data
s_rresp  in  2  slave read response
s_rvalid  in  1  slave data valid
s_rready  out  1  slave data ready
ifu_grants  out  CW  completed IFU reads
lsu_grants  out  CW  completed LSU reads

Behaviour:
- Registered state: `state` ∈ {IDLE, ADDR, DATA}, `grant` (0 = IFU, 1 = LSU), `last` (last master served), two counters.
- Reset (reset = 0, asynchronous): state = IDLE, grant = 0, last = 1 (IFU wins first tie), counters = 0.
  - All valid/ready outputs are 0.
  - s_araddr and all master rdata/rresp outputs are 0.
  - Reset mid-transaction abandons the transaction. The slave is reset by the same signal.
- IDLE:
  - No grant. All arready/rvalid/s_arvalid/s_rready are 0.
  - If wr_busy = 0 and any arvalid = 1: register grant and go to ADDR.
  - Only one requester: grant it.
  - Both requesting: grant the master ≠ last.
  - wr_busy = 1: stay in IDLE regardless of requests.
- ADDR:
  - s_arvalid = arvalid of the granted master; s_araddr = its araddr.
  - Granted master's arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready: go to DATA.
  - If the granted master drops arvalid (protocol violation): stay in ADDR; no re-arbitration.
- DATA:
  - Granted master sees rvalid = s_rvalid, rdata = s_rdata, rresp = s_rresp. s_rready = that master's rready.
  - The non-granted master sees rvalid = 0, rdata = 0, rresp = 0.
  - On s_rvalid & s_rready: set last = grant, increment that master's counter, go to IDLE.
  - The rresp value is forwarded unmodified. SLVERR/DECERR still count as completed.
- Latency: arvalid rising in cycle N (IDLE, wr_busy = 0) gives s_arvalid = 1 in cycle N+1.
  - Minimum cycles from request to data handshake = 3 with a zero-wait slave.
  - At least 1 IDLE cycle separates back-to-back transactions.
- Counters wrap modulo 2^CW without saturation.
- No combinational path from any master input to another master's outputs.
- The only paths from s_* inputs to outputs go through the granted-master mux.
- Address/data widths pass through with no truncation or extension.

Test Plan:
- Single IFU read: ifu_arvalid = 1, araddr = 0x8000_0000; slave has arready = 1 and returns rdata = 0xDEAD_BEEF, rresp = 0 one cycle later -> s_araddr = 0x8000_0000 in cycle 1; ifu_rvalid with 0xDEAD_BEEF in cycle 2; ifu_grants = 1; lsu_arready stays 0 throughout.
- Simultaneous requests after reset: both arvalid = 1 with addrs 0x100 and 0x200 -> IFU served first (0x100), then LSU (0x200), then IFU; grant order alternates I, L, I, L over 4 transactions; each counter = 2.
- Write ordering: wr_busy = 1 for 5 cycles while lsu_arvalid = 1 -> s_arvalid = 0 for all 5 cycles; s_arvalid = 1 the cycle after wr_busy falls.
- Backpressure: slave arready low 3 cycles, rvalid high while lsu_rready low 2 cycles -> LSU address held stable on s_araddr; rdata held; exactly one handshake; lsu_grants increments by 1.
- Error response: slave returns rresp = 2'b10 -> lsu_rresp = 2'b10 forwarded; FSM returns to IDLE; lsu_grants increments.
- Async reset in DATA: reset low mid-cycle -> all valid/ready outputs 0 immediately; counters 0; after release the first request completes normally.
